// File: rtl/data_mem_unit.sv
// Data-memory stage: word-organised array behind the EXE register, with a
// wait-state FSM that freezes earlier stages. Optional macro: MEM_ALIGN_CHECK_EN.
module data_mem_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              freeze,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              req, done;
  logic [31:0]       diff;
  logic [29:0]       word_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range, misaligned, access_ok;
  logic              unused_addr_bits;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req      = mem_r_en | mem_w_en;
  assign diff     = addr - BASE_ADDR;
  assign word_off = diff[31:2];
  assign idx      = word_off[IDX_W-1:0];
  assign in_range = (addr >= BASE_ADDR) && ({2'b00, word_off} < DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
  assign err        = done && !(in_range && !misaligned);
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign access_ok        = in_range && !misaligned;
  assign unused_addr_bits = ^{diff[1:0], word_off, addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A dropped request while waiting is a pipeline flush: abort without completing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    freeze   = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            freeze   = 1'b1;
            cnt_nx   = 4'(WAIT_CYCLES - 1);
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else if (cnt != 4'd0) begin
          freeze = 1'b1;
          cnt_nx = cnt - 4'd1;
        end else begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ready = done;
  assign rdata = (done && !mem_w_en && access_ok) ? mem[idx] : '0;

  // No reset on the array; a reset edge only discards a write completing with it.
  always_ff @(posedge clk) begin
    if (!rst && done && mem_w_en && access_ok) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: zero-wait and 3-wait instances checked
// against a word-array reference model with directed and random accesses.
module tb_data_mem_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en   [2];
  logic        w_en   [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        freeze [2];
  logic        err    [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][DEPTH];
  bit          known [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_unit #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .freeze(freeze[0]), .err(err[0])
  );

  data_mem_unit #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .freeze(freeze[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < DEPTH);
  endfunction

  function automatic bit allowed(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return in_range(a) && (a % 4 == 0);
`else
    return in_range(a);
`endif
  endfunction

  task automatic clear(input int d);
    r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
  endtask

  task automatic idle_check(input int d, input string tag);
    @(negedge clk);
    check({tag, ".ready"},  ready[d],  0);
    check({tag, ".freeze"}, freeze[d], 0);
    check({tag, ".rdata"},  rdata[d],  0);
    check({tag, ".err"},    err[d],    0);
    @(posedge clk); #1;
  endtask

  // Presents one request, follows it to completion and updates the model.
  task automatic access(input int d, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int          n    = (d == 0) ? 0 : 3;
    int          cyc  = 0;
    bit          fin  = 0;
    bit          ok   = allowed(a);
    int unsigned w    = ok ? (a - BASE) / 4 : 0;
    bit          rd_chk;
    logic [31:0] exp_rd;
    bit          exp_err;
`ifdef MEM_ALIGN_CHECK_EN
    exp_err = !ok;
`else
    exp_err = 1'b0;
`endif
    if (we || !ok) begin
      rd_chk = 1; exp_rd = '0;
    end else begin
      rd_chk = known[d][w]; exp_rd = model[d][w];
    end
    w_en[d] = we; r_en[d] = re; addr[d] = a; wdata[d] = wd;
    while (!fin) begin
      @(negedge clk);
      if (ready[d]) begin
        check({tag, ".latency"}, cyc, n);
        check({tag, ".freeze_done"}, freeze[d], 0);
        if (rd_chk) check({tag, ".rdata"}, rdata[d], exp_rd);
        check({tag, ".err"}, err[d], exp_err);
        fin = 1;
      end else begin
        check({tag, ".freeze"}, freeze[d], 1);
        cyc++;
        if (cyc > 20) begin
          check({tag, ".timeout"}, cyc, n);
          fin = 1;
        end
      end
      @(posedge clk); #1;
    end
    if (we && ok) begin
      model[d][w] = wd;
      known[d][w] = 1;
    end
    clear(d);
  endtask

  initial begin
    logic [31:0] a;
    int          kind, op;

    rst = 1'b1;
    clear(0); clear(1);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      check("rst.ready",  ready[d],  0);
      check("rst.freeze", freeze[d], 0);
      check("rst.rdata",  rdata[d],  0);
      check("rst.err",    err[d],    0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    access(0, 1, 0, 1024, 32'hDEADBEEF, "z_wr");
    access(0, 0, 1, 1024, '0, "z_rd");

    access(1, 1, 0, 1028, 32'h12345678, "w_wr");
    access(1, 0, 1, 1028, '0, "w_rd");

    // Flush: request withdrawn after one stall cycle
    access(1, 1, 0, 1032, 32'h0, "fl_init");
    w_en[1] = 1'b1; addr[1] = 1032; wdata[1] = 32'hFF;
    @(negedge clk);
    check("fl.freeze0", freeze[1], 1);
    @(posedge clk); #1;
    clear(1);
    @(negedge clk);
    check("fl.freeze1", freeze[1], 0);
    check("fl.ready1",  ready[1],  0);
    @(posedge clk); #1;
    idle_check(1, "fl.idle");
    access(1, 0, 1, 1032, '0, "fl_rd");

    // Reset in the second wait cycle of a write
    access(1, 1, 0, 1036, 32'h55, "rs_init");
    w_en[1] = 1'b1; addr[1] = 1036; wdata[1] = 32'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear(1);
    idle_check(1, "rs.after");
    access(1, 0, 1, 1036, '0, "rs_rd");

    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1, BASE - 4, '0, "oor_lo");
      access(d, 0, 1, BASE + 4 * DEPTH, '0, "oor_hi");
      access(d, 1, 0, BASE + 4 * DEPTH, 32'h77, "oor_wr");
      access(d, 1, 0, 1024, 32'h11111111, "mis_init");
      access(d, 1, 0, 1026, 32'hCAFEF00D, "mis_wr");
      access(d, 0, 1, 1024, '0, "mis_rd");
      access(d, 1, 1, 1040, 32'hA5A5A5A5, "both_wr");
      access(d, 0, 1, 1040, '0, "both_rd");
    end

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0:       a = BASE - 4 * $urandom_range(1, 4);
          1:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
          2:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
          default: a = BASE + 4 * $urandom_range(0, 15);
        endcase
        op = $urandom_range(0, 2);
        access(d, op != 0, op != 1, a, $urandom, "rnd");
        if ($urandom_range(0, 4) == 0) idle_check(d, "rnd.idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory stage for the 5-stage ARM pipeline, sitting between the EXE stage register and the MEM stage register. It decodes byte addresses from the ALU result into a word-organised array, runs a wait-state state machine for slow memory, and raises `freeze` to stall the earlier stages until each access completes. The width, depth, base address and latency are generalised, and a cycle-exact stall handshake is added.

## Interface
- `DATA_W`, 32: data word width; it must be a multiple of 8.
- `DEPTH`, 64: number of words in the array.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 0: stall cycles per access, in the range 0..15.
- `clk`  in  1  the single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_r_en`  in  1  read request; held stable while `freeze`=1.
- `mem_w_en`  in  1  write request; held stable while `freeze`=1.
- `addr`  in  32  byte address, the ALU result.
- `wdata`  in  DATA_W  store data, the Val_Rm value.
- `rdata`  out  DATA_W  load data; valid only while `ready`=1, otherwise 0.
- `ready`  out  1  the access completes in this cycle.
- `freeze`  out  1  stalls the IF, ID and EXE stages and the EXE register.
- `err`  out  1  one-cycle pulse on a faulting access (see Configuration).

## Operation
- Word index: `idx = (addr - BASE_ADDR) >> 2`, computed in 32-bit unsigned arithmetic.
- An address is in range when `addr >= BASE_ADDR` and `idx < DEPTH`.
- Write precedence: if `mem_r_en` and `mem_w_en` are both high, the access is treated as a write and `rdata`=0.
- Out-of-range accesses:
  - A write is dropped.
  - A read returns 0.
  - The access still completes with the normal latency.
- The array has no reset; its contents survive `rst`.
- State machine, states IDLE and WAIT, with a 4-bit counter `cnt`:
  - IDLE with no request: `freeze`=0, `ready`=0.
  - IDLE with a request and `WAIT_CYCLES`=0: `ready`=1, `freeze`=0. A read is served combinationally. A write commits at the closing edge. The state stays IDLE.
  - IDLE with a request and `WAIT_CYCLES`>0: `freeze`=1 (combinational from the request), `cnt` <= `WAIT_CYCLES`-1, go to WAIT.
  - WAIT with `cnt`!=0: `freeze`=1, `cnt` decrements.
  - WAIT with `cnt`==0: `freeze`=0, `ready`=1. The access completes as in the zero-wait case. Go to IDLE.
  - WAIT with both requests low (a pipeline flush): abort. No write happens, `ready`=0, `freeze`=0, go to IDLE at the next edge.
- Back-to-back accesses: the request presented in the cycle after completion is accepted from IDLE.

## Timing
- Reset values: state IDLE, `cnt`=0, `freeze`=0, `ready`=0, `rdata`=0, `err`=0.
- A request first presented in cycle T:
  - `freeze` is high in cycles T..T+N-1, where N=`WAIT_CYCLES`.
  - `ready` is high in cycle T+N.
  - A write is visible to reads from cycle T+N+1.
- Read latency is N cycles of stall; `rdata` is combinational from the array during the `ready` cycle.
- `rst` during WAIT: IDLE next cycle, the pending write is discarded, `freeze` drops the cycle after the reset edge.
- `err` is asserted only in the `ready` cycle.
- Throughput: one access per N+1 cycles.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `addr[1:0]`!=0, or an out-of-range address, pulses `err`=1 in its `ready` cycle.
  - A write with a misaligned address is suppressed, and `rdata`=0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `addr[1:0]` is ignored; the word is truncated and the access goes ahead.
  - `err` is tied to 0.
- Range handling is identical in both builds.

## Test plan
- `WAIT_CYCLES`=0: write 32'hDEADBEEF to 1024, then read 1024 -> `ready`=1 each cycle, `freeze` never high, `rdata`=32'hDEADBEEF.
- `WAIT_CYCLES`=3: read 1028 after writing 32'h12345678 -> `freeze` high for 3 cycles, `ready` in the 4th, `rdata`=32'h12345678.
- `WAIT_CYCLES`=3: drop `mem_w_en` after 1 stall cycle while writing 32'hFF to 1032 -> `freeze` low in the next cycle; a later read of 1032 returns the old value 0 (the location was previously written 0).
- Assert `rst` in the 2nd WAIT cycle of a write to 1036 -> outputs 0 the next cycle; a read of 1036 returns the prior value.
- Read 1020, and read 1024+4*`DEPTH` -> `rdata`=0 with normal latency; `err`=1 only in a `MEM_ALIGN_CHECK_EN` build.
- With `MEM_ALIGN_CHECK_EN`, write to 1026 -> `err` pulse, the word at 1024 is unchanged. Without the macro, the same write updates word 1024 and `err`=0.
